// File: rtl/cn0363_lockin_pkg.sv
// Shared definitions for the CN0363 lock-in mixer: sample width, quadrant
// encodings, quarter-turn phase constant, output shift and sine table values.
package cn0363_lockin_pkg;

    localparam int SAMPLE_W = 24;
    localparam logic [31:0] QUARTER_PHASE = 32'h4000_0000;

    // Top two phase bits select the quadrant of the full sine wave.
    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_e;

    // Right shift from the full product width down to the output width.
    function automatic int out_shift(input int coef_w, input int out_w);
        return SAMPLE_W + coef_w - out_w;
    endfunction

    // Quarter-wave entry k, sampled at the centre of its bin (k + 0.5) so
    // there is no 0 or 90 degree endpoint and every value negates safely.
    function automatic int sine_entry(input int k, input int addr_w,
                                      input int coef_w);
        real amp;
        real x;
        amp = real'((1 << (coef_w - 1)) - 1);
        x = 1.5707963267948966 * (real'(k) + 0.5) / real'(1 << addr_w);
        return $rtoi(amp * $sin(x) + 0.5);
    endfunction

endpackage

// File: rtl/cn0363_sine_lut.sv
// Quarter-wave sine ROM with quadrant fold and one registered read port.
// Ports: clk, reset (async, high), en (advance), addr (32-bit phase), coef.
module cn0363_sine_lut
    import cn0363_lockin_pkg::*;
#(
    parameter int LUT_ADDR_W = 10,
    parameter int COEF_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [31:0]              addr,
    output logic signed [COEF_W-1:0] coef
);

    localparam int DEPTH = 1 << LUT_ADDR_W;

    logic [COEF_W-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam int ENTRY = sine_entry(i, LUT_ADDR_W, COEF_W);
        assign rom[i] = ENTRY[COEF_W-1:0];
    end

    quad_e                   quad;
    logic [LUT_ADDR_W-1:0]   k;
    logic [LUT_ADDR_W-1:0]   idx;
    logic                    neg;
    logic [COEF_W-1:0]       mag;
    logic signed [COEF_W-1:0] coef_d;
    logic signed [COEF_W-1:0] coef_q;
    logic                    unused_addr;

    assign quad = quad_e'(addr[31:30]);
    assign k = addr[29 -: LUT_ADDR_W];
    // Phase bits below the table resolution are dropped.
    assign unused_addr = ^addr;

    always_comb begin
        idx = k;
        neg = 1'b0;
        unique case (quad)
            QUAD_0: begin idx = k;  neg = 1'b0; end
            QUAD_1: begin idx = ~k; neg = 1'b0; end
            QUAD_2: begin idx = k;  neg = 1'b1; end
            QUAD_3: begin idx = ~k; neg = 1'b1; end
        endcase
        mag = rom[idx];
        coef_d = coef_q;
        if (en) begin
            coef_d = neg ? -$signed(mag) : $signed(mag);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coef_q <= '0;
        end else begin
            coef_q <= coef_d;
        end
    end

    assign coef = coef_q;

endmodule

// File: rtl/cn0363_lockin_mixer.sv
// CN0363 lock-in mixer: joins sample and phase streams, multiplies each
// sample by cos/sin of (phase + phase_offset) and emits {Q, I}.
// Ports: clk, reset (async, high), phase_offset, s_axis_sample_*,
// s_axis_phase_*, m_axis_iq_*.
// Build option: CN0363_LOCKIN_ROUND_EN selects round-half-up with positive
// saturation; otherwise outputs are truncated by arithmetic shift.
module cn0363_lockin_mixer
    import cn0363_lockin_pkg::*;
#(
    parameter int LUT_ADDR_W = 10,
    parameter int COEF_W     = 16,
    parameter int OUT_W      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          phase_offset,
    input  logic                 s_axis_sample_valid,
    output logic                 s_axis_sample_ready,
    input  logic [SAMPLE_W-1:0]  s_axis_sample_data,
    input  logic                 s_axis_phase_valid,
    output logic                 s_axis_phase_ready,
    input  logic [31:0]          s_axis_phase_data,
    output logic                 m_axis_iq_valid,
    input  logic                 m_axis_iq_ready,
    output logic [2*OUT_W-1:0]   m_axis_iq_data
);

    localparam int PROD_W = SAMPLE_W + COEF_W;
    localparam int SHIFT  = out_shift(COEF_W, OUT_W);

    logic en;
    logic xfer;

    logic                       v1_d, v1_q;
    logic [31:0]                phase_d, phase_q;
    logic signed [SAMPLE_W-1:0] s1_d, s1_q;
    logic                       v2_d, v2_q;
    logic signed [SAMPLE_W-1:0] s2_d, s2_q;
    logic                       vo_d, vo_q;
    logic [2*OUT_W-1:0]         iq_d, iq_q;

    logic signed [COEF_W-1:0]   sin_c;
    logic signed [COEF_W-1:0]   cos_c;
    logic signed [PROD_W-1:0]   prod_i;
    logic signed [PROD_W-1:0]   prod_q;
    logic signed [OUT_W-1:0]    res_i;
    logic signed [OUT_W-1:0]    res_q;
    logic                       unused_bits;

    // One enable for every stage: the pipeline moves only as a whole.
    assign en = ~vo_q | m_axis_iq_ready;
    assign xfer = s_axis_sample_valid & s_axis_phase_valid & en;

    assign s_axis_sample_ready = en & s_axis_phase_valid & ~reset;
    assign s_axis_phase_ready  = en & s_axis_sample_valid & ~reset;

    cn0363_sine_lut #(
        .LUT_ADDR_W (LUT_ADDR_W),
        .COEF_W     (COEF_W)
    ) u_sin (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .addr  (phase_q),
        .coef  (sin_c)
    );

    cn0363_sine_lut #(
        .LUT_ADDR_W (LUT_ADDR_W),
        .COEF_W     (COEF_W)
    ) u_cos (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .addr  (phase_q + QUARTER_PHASE),
        .coef  (cos_c)
    );

    assign prod_i = s2_q * cos_c;
    assign prod_q = s2_q * sin_c;

`ifdef CN0363_LOCKIN_ROUND_EN
    localparam logic [PROD_W:0] ONE = 1;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [PROD_W:0] RND = (SHIFT > 0) ? (ONE << RND_SH) : '0;
    localparam logic signed [PROD_W:0] SAT_MAX =
        {{(PROD_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};

    logic signed [PROD_W:0] wide_i, wide_q;
    logic signed [PROD_W:0] rsh_i, rsh_q;

    // One guard bit keeps the rounding add from wrapping.
    assign wide_i = {prod_i[PROD_W-1], prod_i} + RND;
    assign wide_q = {prod_q[PROD_W-1], prod_q} + RND;
    assign rsh_i = wide_i >>> SHIFT;
    assign rsh_q = wide_q >>> SHIFT;
    // Rounding only adds, so only the positive side can overflow.
    assign res_i = (rsh_i > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : rsh_i[OUT_W-1:0];
    assign res_q = (rsh_q > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : rsh_q[OUT_W-1:0];
    assign unused_bits = ^{prod_i, prod_q, rsh_i, rsh_q};
`else
    // Taking the top OUT_W bits is the arithmetic right shift.
    assign res_i = prod_i[PROD_W-1 -: OUT_W];
    assign res_q = prod_q[PROD_W-1 -: OUT_W];
    assign unused_bits = ^{prod_i, prod_q};
`endif

    always_comb begin
        v1_d    = v1_q;
        phase_d = phase_q;
        s1_d    = s1_q;
        v2_d    = v2_q;
        s2_d    = s2_q;
        vo_d    = vo_q;
        iq_d    = iq_q;
        if (en) begin
            v1_d    = xfer;
            phase_d = s_axis_phase_data + phase_offset;
            s1_d    = s_axis_sample_data;
            v2_d    = v1_q;
            s2_d    = s1_q;
            vo_d    = v2_q;
            iq_d    = {res_q, res_i};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q    <= 1'b0;
            phase_q <= '0;
            s1_q    <= '0;
            v2_q    <= 1'b0;
            s2_q    <= '0;
            vo_q    <= 1'b0;
            iq_q    <= '0;
        end else begin
            v1_q    <= v1_d;
            phase_q <= phase_d;
            s1_q    <= s1_d;
            v2_q    <= v2_d;
            s2_q    <= s2_d;
            vo_q    <= vo_d;
            iq_q    <= iq_d;
        end
    end

    assign m_axis_iq_valid = vo_q;
    assign m_axis_iq_data  = iq_q;

endmodule
